// File: rtl/even_fib_generator_pkg.sv
// Shared constants and FSM encoding for the odd-term Fibonacci stream generator.
package even_fib_pkg;
  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/even_fib_generator_if.sv
// Start/done control plus valid/ready output stream between the generator and its consumer.
interface even_fib_generator_if import even_fib_pkg::*; #(
  parameter int WIDTH = even_fib_pkg::WIDTH
) ();
  logic                    __start;
  logic                    __ready;
  logic signed [WIDTH-1:0] n;
  logic                    __done;
  logic                    __valid;
  logic signed [WIDTH-1:0] __output_0;

  modport master (
    input  __start, __ready, n,
    output __done, __valid, __output_0
  );

  modport slave (
    output __start, __ready, n,
    input  __done, __valid, __output_0
  );
endinterface

// File: rtl/even_fib_generator.sv
// Walks a = 0,1,1,2,3,5,... while a < n, yielding each odd term as one registered beat.
// One iteration per cycle; a pending beat that is not accepted freezes the whole datapath.
module even_fib_generator import even_fib_pkg::*; #(
  parameter int WIDTH = even_fib_pkg::WIDTH
) (
  input  logic                 __clock,
  input  logic                 __reset,
  even_fib_generator_if.master bus
);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] n_q, n_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] b_q, b_d;
  logic        [WIDTH-1:0] i_q, i_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    stall;

  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    out_d   = out_q;
    done_d  = done_q;
    valid_d = valid_q;
    stall   = valid_q && !bus.__ready;

    case (state_q)
      IDLE, DONE: begin
        if (bus.__start) begin
          n_d     = bus.n;
          a_d     = '0;
          b_d     = ONE;
          i_d     = '0;
          done_d  = 1'b0;
          valid_d = 1'b0;
          state_d = LOOP;
        end
      end
      LOOP: begin
        if (!stall) begin
          valid_d = 1'b0;
          if (a_q < n_q) begin
            if (a_q[0]) begin
              out_d   = a_q;
              valid_d = 1'b1;
            end
            // Sum wraps in two's complement; the signed compare keeps running past a wrap.
            a_d = b_q;
            b_d = a_q + b_q;
            i_d = i_q + ONE;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge __clock) begin
    if (__reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      a_q     <= '0;
      b_q     <= ONE;
      i_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      out_q   <= out_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign bus.__done     = done_q;
  assign bus.__valid    = valid_q;
  assign bus.__output_0 = out_q;

endmodule

// File: tb/tb_even_fib_generator.sv
// Directed and randomized checks of even_fib_generator against a plain-arithmetic sequence model.
module tb_even_fib_generator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_q[$];

  even_fib_generator_if #(.WIDTH(32)) bus ();

  even_fib_generator #(.WIDTH(32)) dut (
    .__clock (clk),
    .__reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Odd terms of the Fibonacci sequence that lie strictly below lim.
  function automatic void build_expected(input int lim);
    int a, b, t;
    exp_q.delete();
    a = 0;
    b = 1;
    for (int k = 0; k < 200 && a < lim; k++) begin
      if (a % 2 != 0) exp_q.push_back(a);
      t = a + b;
      a = b;
      b = t;
    end
  endfunction

  // Pulse start for one cycle; returns at the negedge after the sampling posedge.
  task automatic start_run(input int lim);
    @(negedge clk);
    bus.__start = 1'b1;
    bus.n       = lim;
    @(negedge clk);
    bus.__start = 1'b0;
    bus.n       = $urandom;
  endtask

  // Consume beats until done, checking order, values, stall stability and done/valid exclusion.
  task automatic run_and_check(input string tag, input bit rand_ready, input int budget,
                               input int poke_cyc);
    int          got;
    bit          prev_stall;
    bit          done_seen;
    logic [31:0] prev_out;
    logic        rdy;
    got        = 0;
    prev_stall = 1'b0;
    done_seen  = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
      if (prev_stall) begin
        check({tag, "_stall_valid"}, 32'(bus.__valid), 32'd1);
        check({tag, "_stall_data"}, bus.__output_0, prev_out);
      end
      if (bus.__done && bus.__valid) check({tag, "_done_valid_excl"}, 32'd1, 32'(1'b0 & bus.__valid));
      if (bus.__done) begin
        done_seen = 1'b1;
        check({tag, "_beat_count"}, got, exp_q.size());
        check({tag, "_valid_at_done"}, 32'(bus.__valid), 32'd0);
      end else begin
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.__ready = rdy;
        bus.__start = (cyc == poke_cyc);
        bus.n       = 3;
        if (bus.__valid && rdy) begin
          if (got < exp_q.size()) check({tag, "_beat"}, bus.__output_0, exp_q[got]);
          else                    check({tag, "_extra_beat"}, bus.__output_0, 32'hxxxx_xxxx);
          got++;
        end
        prev_stall = bus.__valid && !rdy;
        prev_out   = bus.__output_0;
        @(negedge clk);
      end
    end
    bus.__start = 1'b0;
    bus.__ready = 1'b1;
    check({tag, "_done_timeout"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    int got;
    int lim;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.__start = 1'b0;
    bus.__ready = 1'b0;
    bus.n       = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_done", 32'(bus.__done), 32'd0);
    check("reset_valid", 32'(bus.__valid), 32'd0);
    check("reset_output", bus.__output_0, 32'd0);
    rst = 1'b0;
    bus.__ready = 1'b1;

    // Always-ready runs
    build_expected(10);
    start_run(10);
    run_and_check("n10", 1'b0, 200, -1);
    build_expected(100);
    start_run(100);
    run_and_check("n100", 1'b0, 200, -1);

    // Non-positive limits: no beats, done two cycles after start
    foreach (exp_q[k]) exp_q[k] = exp_q[k];
    for (int t = 0; t < 2; t++) begin
      lim = (t == 0) ? 0 : -5;
      start_run(lim);
      check("nonpos_done_early", 32'(bus.__done), 32'd0);
      check("nonpos_valid_early", 32'(bus.__valid), 32'd0);
      @(negedge clk);
      check("nonpos_done", 32'(bus.__done), 32'd1);
      check("nonpos_valid", 32'(bus.__valid), 32'd0);
    end

    // Backpressure with pseudo-random ready
    build_expected(100);
    start_run(100);
    run_and_check("n100_bp", 1'b1, 400, -1);

    // Reset after the second beat
    start_run(100);
    bus.__ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 50 && got < 2; cyc++) begin
      if (bus.__valid) begin
        check("rst_pre_beat", bus.__output_0, 32'd1);
        got++;
      end
      if (got < 2) @(negedge clk);
    end
    check("rst_pre_count", got, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(bus.__valid), 32'd0);
    check("rst_done", 32'(bus.__done), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_idle_quiet", 32'(bus.__valid | bus.__done), 32'd0);
    build_expected(2);
    start_run(2);
    run_and_check("n2_after_rst", 1'b0, 100, -1);

    // Restart from DONE, with a start pulse injected mid-run
    build_expected(10);
    start_run(10);
    check("restart_done_drop", 32'(bus.__done), 32'd0);
    run_and_check("n10_restart", 1'b0, 200, 3);

    // Randomized limits with random backpressure
    for (int r = 0; r < 12; r++) begin
      lim = int'($urandom_range(0, 2000000)) - 20;
      build_expected(lim);
      start_run(lim);
      run_and_check($sformatf("rand%0d", r), 1'b1, 600, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
